// File: rtl/dcs_score_norm.sv
// dcs_score_norm: collects a frame of NUM unsigned scores, finds the first-occurrence
// argmax, then streams every score right-shifted so the frame maximum fits in OW bits.
// Output stream is valid/ready; input beats arriving while the frame is being
// normalized or sent are dropped and flagged on ovf one cycle later.
module dcs_score_norm #(
   parameter int NUM = 8,
   parameter int IW  = 32,
   parameter int OW  = 8
) (
   input  logic          clk,
   input  logic          rst_n,      // active-high synchronous reset
   input  logic          in_valid,
   input  logic [IW-1:0] in_data,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [OW-1:0] out_data,
   output logic [2:0]    out_idx,
   output logic          out_last,
   output logic          ovf
);

   localparam int CW = (NUM > 1) ? $clog2(NUM) : 1;
   localparam int SW = (IW > 1) ? $clog2(IW) : 1;
   localparam logic [CW-1:0] LAST = CW'(NUM - 1);

   typedef enum logic [1:0] {
      COLLECT,
      NORM,
      SEND
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   k_q;
   logic [CW-1:0]   idx_q;
   logic [IW-1:0]   max_q;
   logic [SW-1:0]   s_q;
   logic [IW-1:0]   score_q [NUM];

   logic            out_valid_q;
   logic [OW-1:0]   out_data_q;
   logic [2:0]      out_idx_q;
   logic            out_last_q;
   logic            ovf_q;

   logic [SW-1:0]   max_msb;
   logic [SW-1:0]   s_d;
   logic [CW-1:0]   rd_k_d;
   logic [SW-1:0]   rd_s_d;
   logic [OW-1:0]   data_d;
   logic            accept;

   assign accept = in_valid && (state_q == COLLECT);

   // Shift amount from the running max and the next normalized word to present.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      max_msb = '0;
      for (int i = 0; i < IW; i++) begin
         if (max_q[i]) max_msb = SW'(i);
      end
      s_d = (max_msb > SW'(OW - 1)) ? (max_msb - SW'(OW - 1)) : '0;

      // NORM presents word 0 with the freshly computed shift; SEND presents word k+1.
      rd_k_d = (state_q == NORM) ? '0 : (k_q + CW'(1));
      rd_s_d = (state_q == NORM) ? s_d : s_q;
      data_d = OW'(score_q[rd_k_d] >> rd_s_d);
   end

   // Score buffer written on each accepted beat.
   // NOTE: the buffer is deliberately left out of reset; every slot is rewritten
   // before it is read, and resetting a memory costs a mux on every bit.
   always_ff @(posedge clk) begin
      if (accept) score_q[cnt_q] <= in_data;
   end

   // Frame FSM: collect with running argmax, one-cycle normalize, then stream out.
   always_ff @(posedge clk) begin
      // NOTE: all state here uses non-blocking assignments so every register samples
      // the pre-edge values, independent of statement order.
      if (rst_n) begin
         state_q     <= COLLECT;
         cnt_q       <= '0;
         k_q         <= '0;
         idx_q       <= '0;
         max_q       <= '0;
         s_q         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         ovf_q <= in_valid && (state_q != COLLECT);
         case (state_q)
            COLLECT: begin
               if (in_valid) begin
                  if ((cnt_q == '0) || (in_data > max_q)) begin
                     max_q <= in_data;
                     idx_q <= cnt_q;
                  end
                  if (cnt_q == LAST) begin
                     cnt_q   <= '0;
                     state_q <= NORM;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            NORM: begin
               s_q         <= s_d;
               k_q         <= '0;
               out_valid_q <= 1'b1;
               out_data_q  <= data_d;
               out_idx_q   <= 3'(idx_q);
               out_last_q  <= (NUM == 1);
               state_q     <= SEND;
            end
            SEND: begin
               if (out_ready) begin
                  if (k_q == LAST) begin
                     state_q     <= COLLECT;
                     k_q         <= '0;
                     cnt_q       <= '0;
                     max_q       <= '0;
                     idx_q       <= '0;
                     out_valid_q <= 1'b0;
                     out_data_q  <= '0;
                     out_idx_q   <= '0;
                     out_last_q  <= 1'b0;
                  end else begin
                     k_q        <= k_q + CW'(1);
                     out_data_q <= data_d;
                     out_last_q <= ((k_q + CW'(1)) == LAST);
                  end
               end
            end
            default: state_q <= COLLECT;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_dcs_score_norm.sv
// Testbench for dcs_score_norm: directed frames plus randomized frames, all checked
// every cycle against a frame-level reference model kept in the bench.
module tb_dcs_score_norm;

   localparam int NUM = 8;
   localparam int IW  = 32;
   localparam int OW  = 8;

   typedef logic [IW-1:0] frame_t [NUM];
   typedef struct {
      logic [OW-1:0] data;
      logic [2:0]    idx;
      logic          last;
   } out_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [IW-1:0] in_data;
   logic          out_ready;
   logic          out_valid;
   logic [OW-1:0] out_data;
   logic [2:0]    out_idx;
   logic          out_last;
   logic          ovf;

   always #5 clk = ~clk;

   dcs_score_norm #(.NUM(NUM), .IW(IW), .OW(OW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .ovf       (ovf)
   );

   int n_vec = 0;
   int n_err = 0;
   int n_ovf = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: argmax keeps the first of equal maxima; the shift is the smallest
   // one that makes the maximum fit in OW bits.
   function automatic void model_frame(input frame_t f, output out_t r [NUM]);
      longint unsigned mx;
      int ai;
      int s;
      mx = f[0];
      ai = 0;
      for (int i = 1; i < NUM; i++) begin
         if (f[i] > mx) begin
            mx = f[i];
            ai = i;
         end
      end
      s = 0;
      while ((mx >> s) > ((64'd1 << OW) - 1)) s++;
      for (int i = 0; i < NUM; i++) begin
         r[i].data = OW'(f[i] >> s);
         r[i].idx  = 3'(ai);
         r[i].last = (i == NUM - 1);
      end
   endfunction

   // Cycle-level model state: beats accepted so far, pending outputs of the
   // frame in flight, and the expected output values for the current cycle.
   logic [IW-1:0] acc [$];
   out_t          outs [$];
   bit            m_busy = 0;
   bit            m_pend = 0;
   logic          e_valid = 1'b0;
   logic          e_ovf = 1'b0;
   out_t          e_cur;
   bit            cmp_en = 0;
   out_t          got [$];

   always @(posedge clk) begin : model
      bit     hs;
      frame_t fr;
      out_t   r [NUM];
      if (rst_n) begin
         acc.delete();
         outs.delete();
         m_busy  = 0;
         m_pend  = 0;
         e_valid = 1'b0;
         e_ovf   = 1'b0;
      end else begin
         hs    = e_valid && out_ready;
         e_ovf = in_valid && m_busy;
         if (!m_busy) begin
            if (in_valid) begin
               acc.push_back(in_data);
               if (acc.size() == NUM) begin
                  for (int i = 0; i < NUM; i++) fr[i] = acc[i];
                  model_frame(fr, r);
                  outs.delete();
                  for (int i = 0; i < NUM; i++) outs.push_back(r[i]);
                  acc.delete();
                  m_busy = 1;
                  m_pend = 1;
               end
            end
         end else if (m_pend) begin
            m_pend  = 0;
            e_valid = 1'b1;
         end else if (hs) begin
            void'(outs.pop_front());
            if (outs.size() == 0) begin
               m_busy  = 0;
               e_valid = 1'b0;
            end
         end
         if (e_valid) e_cur = outs[0];
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("out_valid", out_valid, e_valid);
         check("ovf", ovf, e_ovf);
         if (e_valid) begin
            check("out_data", out_data, e_cur.data);
            check("out_idx", out_idx, e_cur.idx);
            check("out_last", out_last, e_cur.last);
         end
         if (out_valid && out_ready) got.push_back('{out_data, out_idx, out_last});
         if (ovf) n_ovf++;
      end
   end

   bit ready_rand = 0;
   bit noise = 0;
   int n_drop = 0;

   task automatic step();
      @(posedge clk);
      #1;
      out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic send_frame(input frame_t f, input int max_gap);
      for (int i = 0; i < NUM; i++) begin
         repeat ($urandom_range(0, max_gap)) begin
            in_valid = 1'b0;
            step();
         end
         in_valid = 1'b1;
         in_data  = f[i];
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (m_busy && n < 500) begin
         in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         in_data  = $urandom;
         if (in_valid) n_drop++;
         step();
         n++;
      end
      in_valid = 1'b0;
      if (n >= 500) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: frame still in flight after %0d cycles", n);
      end
   endtask

   function automatic logic [IW-1:0] rand_score();
      logic [IW-1:0] v;
      v = $urandom;
      return v >> $urandom_range(0, IW - 1);
   endfunction

   initial begin
      frame_t f;
      out_t   r [NUM];
      int     ovf0;

      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (3) step();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_out_idx", out_idx, 3'd0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      cmp_en = 1;
      rst_n  = 1'b0;
      step();

      // Ramp frame: no shift, argmax at the end, fixed two-cycle latency.
      f = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60, 32'h70, 32'h80};
      model_frame(f, r);
      check("model_ramp_d7", r[7].data, 8'h80);
      check("model_ramp_idx", r[0].idx, 3'd7);
      got.delete();
      send_frame(f, 0);
      check("lat_norm_cycle", out_valid, 1'b0);
      step();
      check("lat_first_valid", out_valid, 1'b1);
      wait_idle();
      check("ramp_count", got.size(), NUM);
      for (int i = 0; i < got.size(); i++) begin
         check("ramp_data", got[i].data, 8'h10 * (i + 1));
         check("ramp_last", got[i].last, i == NUM - 1);
      end

      // Large max in the middle: shift of 5.
      f = '{32'h100, 32'h100, 32'h100, 32'h1234, 32'h100, 32'h100, 32'h100, 32'h100};
      model_frame(f, r);
      check("model_s5_d3", r[3].data, 8'h91);
      check("model_s5_d0", r[0].data, 8'h08);
      got.delete();
      send_frame(f, 2);
      wait_idle();
      check("s5_count", got.size(), NUM);
      if (got.size() == NUM) begin
         check("s5_d3", got[3].data, 8'h91);
         check("s5_d6", got[6].data, 8'h08);
         check("s5_idx", got[0].idx, 3'd3);
      end

      // Tie keeps the first occurrence, then an all-zero frame.
      f = '{32'd5, 32'd9, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      model_frame(f, r);
      check("model_tie_idx", r[0].idx, 3'd1);
      got.delete();
      send_frame(f, 1);
      wait_idle();
      if (got.size() == NUM) check("tie_idx", got[7].idx, 3'd1);
      f = '{default: 32'd0};
      got.delete();
      send_frame(f, 0);
      wait_idle();
      check("zero_count", got.size(), NUM);
      for (int i = 0; i < got.size(); i++) begin
         check("zero_data", got[i].data, 8'h00);
         check("zero_idx", got[i].idx, 3'd0);
      end

      // Full-scale max with a stalling consumer.
      for (int i = 0; i < NUM; i++) f[i] = $urandom_range(0, 32'hFFFF_FFFE);
      f[5] = 32'hFFFF_FFFF;
      model_frame(f, r);
      check("model_s24_d5", r[5].data, 8'hFF);
      ready_rand = 1;
      got.delete();
      send_frame(f, 1);
      wait_idle();
      check("s24_count", got.size(), NUM);
      for (int i = 0; i < got.size(); i++) begin
         check("s24_data", got[i].data, 8'(f[i] >> 24));
         check("s24_order_last", got[i].last, i == NUM - 1);
      end

      // Beats during NORM/SEND are dropped and flagged once each.
      noise = 1;
      for (int i = 0; i < NUM; i++) f[i] = rand_score();
      send_frame(f, 0);
      ovf0   = n_ovf;
      n_drop = 0;
      wait_idle();
      noise = 0;
      step();
      check("ovf_pulse_count", n_ovf - ovf0, n_drop);
      f = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd300, 32'd6, 32'd7, 32'd8};
      got.delete();
      send_frame(f, 1);
      wait_idle();
      if (got.size() == NUM) begin
         check("after_ovf_d4", got[4].data, 8'd150);
         check("after_ovf_idx", got[4].idx, 3'd4);
      end

      // Reset after 5 of 8 inputs, then a fresh frame.
      ready_rand = 0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 32'hFFFF;
         step();
      end
      in_valid = 1'b0;
      rst_n    = 1'b1;
      step();
      rst_n = 1'b0;
      f = '{32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
      got.delete();
      send_frame(f, 0);
      wait_idle();
      check("rst_mid_count", got.size(), NUM);
      if (got.size() == NUM) begin
         check("rst_mid_d0", got[0].data, 8'h08);
         check("rst_mid_d7", got[7].data, 8'h01);
         check("rst_mid_idx", got[0].idx, 3'd0);
      end

      // Reset while a frame is being sent.
      for (int i = 0; i < NUM; i++) f[i] = rand_score();
      send_frame(f, 0);
      repeat (3) step();
      rst_n = 1'b1;
      step();
      rst_n = 1'b0;
      check("rst_send_valid", out_valid, 1'b0);

      // Randomized frames: magnitudes, gaps, stalls and dropped beats.
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < NUM; i++) f[i] = rand_score();
         if ($urandom_range(0, 3) == 0) f[$urandom_range(0, NUM - 1)] = f[$urandom_range(0, NUM - 1)];
         ready_rand = 1'($urandom_range(0, 1));
         noise      = 1'($urandom_range(0, 1));
         send_frame(f, 3);
         wait_idle();
      end
      noise = 0;
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dcs_score_norm.md
DCS_SCORE_NORM -- requirements
Module: dcs_score_norm

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. The clock port SHALL be named clk and the reset port rst_n, following codebase port naming; rst_n=1 at a rising clk edge resets the block.
REQ-002 Parameter NUM, default 8, SHALL set the number of scores per frame.
REQ-003 Parameter IW, default 32, SHALL set the input score width.
REQ-004 Parameter OW, default 8, SHALL set the normalized output width.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  synchronous reset, active-high.
REQ-007 in_valid  input  1  in_data carries one score this cycle (upstream o_valid).
REQ-008 in_data  input  IW  unsigned score; upstream o_data.
REQ-009 out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 out_valid  output  1  out_data/out_idx/out_last are valid.
REQ-011 out_data  output  OW  normalized score.
REQ-012 out_idx  output  3  argmax index of the current frame.
REQ-013 out_last  output  1  marks the final (NUM-th) output of a frame.
REQ-014 ovf  output  1  one-cycle pulse when an in_valid beat is dropped.

Function
REQ-015 The FSM SHALL have three states: COLLECT, NORM and SEND. Reset state is COLLECT.
REQ-016 In COLLECT, each in_valid beat SHALL store in_data into buf[cnt] and increment cnt (0..NUM-1). Gaps in in_valid are allowed.
REQ-017 In COLLECT, a running max/argmax SHALL be updated on a strict-greater compare only, so the first occurrence wins a tie. The first beat of a frame always loads max and idx.
REQ-018 When the NUM-th beat is accepted (cnt==NUM-1), the next state SHALL be NORM and cnt SHALL return to 0.
REQ-019 NORM lasts exactly one cycle. It SHALL register shift s = msb(max) - (OW-1) if msb(max) > OW-1, else s = 0. max==0 gives s=0. The next state is SEND.
REQ-020 In SEND, out_valid=1 and out_data = (buf[k] >> s)[OW-1:0], starting at k=0. Truncation is lossless because buf[k] <= max.
REQ-021 In SEND, out_idx SHALL hold the frame argmax, and out_last SHALL be 1 only when k==NUM-1.
REQ-022 out_data, out_idx and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 A handshake (out_valid & out_ready) SHALL increment k. The handshake at k==NUM-1 SHALL return the FSM to COLLECT with k, cnt and max cleared.
REQ-024 out_valid SHALL be 0 in COLLECT and NORM.
REQ-025 Latency: if the last input beat is at edge T, then NORM occupies T..T+1 and out_valid is first 1 in the cycle after edge T+1. This gives NUM outputs in NUM cycles when out_ready is held at 1.
REQ-026 An in_valid beat in NORM or SEND SHALL be dropped with no state change, and ovf SHALL be 1 in the following cycle.
REQ-027 An in_valid beat in the same cycle as the final SEND handshake SHALL also be dropped (with ovf). It is not counted toward the next frame.
REQ-028 Arithmetic is unsigned. msb() SHALL be a priority encode over IW bits. The shift range is 0..IW-OW.

Reset
REQ-029 While rst_n=1, the block SHALL set out_valid=0, out_data=0, out_idx=0, out_last=0, ovf=0, state=COLLECT, and cnt=k=s=max=0. buf contents need not be cleared.
REQ-030 Reset mid-frame (in COLLECT, NORM or SEND) SHALL discard the partial frame. The first in_valid beat after rst_n falls SHALL be stored as index 0.

Verification
REQ-031 Frame 0x10,0x20,...,0x80 with out_ready=1 -> s=0, outputs 0x10..0x80, out_idx=7, out_last only on the 8th output, first out_valid 2 cycles after the last input.
REQ-032 Frame with max 0x00001234 at index 3 and all others 0x00000100 -> s=5, out_data 0x91 at k=3 and 0x08 elsewhere, out_idx=3.
REQ-033 Frame 5,9,9,0,0,0,0,0 -> out_idx=1 (tie keeps first). Frame all 0 -> eight 0x00 outputs, out_idx=0.
REQ-034 Max 0xFFFFFFFF -> s=24 and out_data 0xFF at the max position. Random out_ready toggling -> outputs stay held while stalled, no sample is lost or duplicated, and the output order is 0..7.
REQ-035 in_valid asserted during SEND -> ovf pulses once per dropped beat and the buffered outputs are unchanged. The next frame is then collected correctly.
REQ-036 rst_n pulsed after 5 of 8 inputs, then a full fresh frame -> outputs reflect only the fresh frame.
